// File: rtl/uart_txrx_if.sv
// Byte-side and serial-pin signals of the uart_txrx transceiver.
// The slave modport is the transceiver's view; master is the core/pin side.
interface uart_txrx_if;
    logic [7:0] tx_byte;
    logic       tx_en;
    logic       tx_ready;
    logic       tx;
    logic       rx;
    logic [7:0] rx_byte;
    logic       byte_read;
    logic       rx_frame_err;

    modport master (
        output tx_byte, tx_en, rx,
        input  tx_ready, tx, rx_byte, byte_read, rx_frame_err
    );

    modport slave (
        input  tx_byte, tx_en, rx,
        output tx_ready, tx, rx_byte, byte_read, rx_frame_err
    );
endinterface

// File: rtl/uart_txrx.sv
// 8N1 UART transceiver: independent TX and RX state machines sharing one
// clock and one baud divisor (CLKS_PER_BIT clock cycles per serial bit).
module uart_txrx #(
    parameter int unsigned CLKS_PER_BIT = 10417
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_txrx_if.slave   bus
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    // ---------------- transmitter ----------------
    uart_state_e   tx_state_q;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]    tx_idx_q;
    logic [7:0]    tx_shift_q;
    logic          tx_q;
    logic          tx_ready_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b0;
        end else begin
            case (tx_state_q)
                ST_IDLE: begin
                    tx_q     <= 1'b1;
                    tx_cnt_q <= '0;
                    // Start bit is driven from the very next cycle.
                    if (bus.tx_en) begin
                        tx_state_q <= ST_START;
                        tx_ready_q <= 1'b0;
                        tx_q       <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tx_cnt_q == CNT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_idx_q   <= '0;
                        tx_shift_q <= bus.tx_byte;
                        tx_q       <= bus.tx_byte[0];
                        tx_state_q <= ST_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt_q == CNT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_idx_q == 3'd7) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= ST_STOP;
                        end else begin
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_q       <= tx_shift_q[1];
                            tx_idx_q   <= tx_idx_q + 3'd1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (tx_cnt_q == CNT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_ready_q <= 1'b1;
                        tx_state_q <= ST_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_ONE;
                    end
                end
                default: tx_state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.tx       = tx_q;
    assign bus.tx_ready = tx_ready_q;

    // ---------------- receiver ----------------
    uart_state_e   rx_state_q;
    logic [1:0]    rx_sync_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_idx_q;
    logic [7:0]    rx_shift_q;
    logic [7:0]    rx_byte_q;
    logic          byte_read_q;
    logic          rx_frame_err_q;
    logic          rx_s;

    assign rx_s = rx_sync_q[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q     <= ST_IDLE;
            rx_sync_q      <= '1;
            rx_cnt_q       <= '0;
            rx_idx_q       <= '0;
            rx_shift_q     <= '0;
            rx_byte_q      <= '0;
            byte_read_q    <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            rx_sync_q      <= {rx_sync_q[0], bus.rx};
            byte_read_q    <= 1'b0;
            rx_frame_err_q <= 1'b0;
            case (rx_state_q)
                ST_IDLE: begin
                    rx_cnt_q <= '0;
                    if (!rx_s) begin
                        rx_state_q <= ST_START;
                    end
                end
                ST_START: begin
                    // Mid-start re-check rejects short glitches on the line.
                    if (rx_cnt_q == CNT_HALF) begin
                        rx_cnt_q <= '0;
                        rx_idx_q <= '0;
                        rx_state_q <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt_q == CNT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                        if (rx_idx_q == 3'd7) begin
                            rx_state_q <= ST_STOP;
                        end else begin
                            rx_idx_q <= rx_idx_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    // Leaving at mid-stop lets a zero-gap next start bit be seen.
                    if (rx_cnt_q == CNT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= ST_IDLE;
                        if (rx_s) begin
                            rx_byte_q   <= rx_shift_q;
                            byte_read_q <= 1'b1;
                        end else begin
                            rx_frame_err_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                default: rx_state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.rx_byte      = rx_byte_q;
    assign bus.byte_read    = byte_read_q;
    assign bus.rx_frame_err = rx_frame_err_q;

endmodule

// File: tb/tb_uart_txrx.sv
// Scoreboard bench for uart_txrx: loopback and directly driven RX frames,
// expected receive events queued at issue time and checked by a monitor.
module tb_uart_txrx;

    localparam int unsigned CPB = 32;

    typedef struct {
        bit         err;
        logic [7:0] data;
    } rx_evt_t;

    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic loop_en = 1'b1;
    logic rx_drv = 1'b1;

    int unsigned n_tests = 0;
    int unsigned n_fail = 0;
    int unsigned n_events = 0;

    rx_evt_t    sb[$];
    logic [7:0] last_good = 8'h00;

    logic prev_br = 1'b0;
    logic prev_fe = 1'b0;

    uart_txrx_if bus ();

    assign bus.rx = loop_en ? bus.tx : rx_drv;

    uart_txrx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected expected event", name);
    endtask

    // Reference model: a received good byte is exactly what was sent;
    // a framing error leaves the last good byte visible.
    function automatic void push_ok(input logic [7:0] b);
        sb.push_back('{err: 1'b0, data: b});
        last_good = b;
    endfunction

    function automatic void push_err();
        sb.push_back('{err: 1'b1, data: last_good});
    endfunction

    function automatic logic frame_bit(input logic [7:0] b, input int unsigned k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.byte_read || bus.rx_frame_err) begin
                n_events++;
                if (sb.size() == 0) begin
                    fail_now("rx_unexpected_event");
                end else begin
                    rx_evt_t e;
                    e = sb.pop_front();
                    chk("rx_frame_err", 32'(bus.rx_frame_err), 32'(e.err));
                    chk("byte_read", 32'(bus.byte_read), 32'(!e.err));
                    chk("rx_byte", 32'(bus.rx_byte), 32'(e.data));
                end
            end
            if (bus.byte_read && prev_br) fail_now("byte_read_pulse_width");
            if (bus.rx_frame_err && prev_fe) fail_now("rx_frame_err_pulse_width");
        end
        prev_br <= bus.byte_read;
        prev_fe <= bus.rx_frame_err;
    end

    task automatic wait_tx_fall(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 4 * CPB; t++) begin
            @(negedge clk);
            if (bus.tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("tx_start_timeout");
    endtask

    task automatic wait_ready_rise(output bit ok);
        bit seen_low = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 12 * CPB; t++) begin
            @(negedge clk);
            if (bus.tx_ready !== 1'b1) seen_low = 1'b1;
            else if (seen_low) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("tx_ready_timeout");
    endtask

    task automatic drain(input int unsigned budget);
        for (int t = 0; t < int'(budget) && sb.size() != 0; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    endtask

    // Full-waveform check of one frame; tx_en is dropped after the latch.
    task automatic check_tx_frame(input logic [7:0] b);
        bit ok;
        wait_tx_fall(ok);
        if (!ok) return;
        for (int unsigned k = 0; k < 10; k++) begin
            int unsigned errs = 0;
            for (int unsigned c = 0; c < CPB; c++) begin
                if (k == 2 && c == 0) bus.tx_en = 1'b0;
                if (bus.tx !== frame_bit(b, k) || bus.tx_ready !== 1'b0) errs++;
                @(negedge clk);
            end
            chk($sformatf("tx_bit%0d_errs", k), 32'(errs), 32'd0);
        end
        chk("tx_ready_at_frame_end", 32'(bus.tx_ready), 32'd1);
        @(negedge clk);
        chk("tx_ready_holds_idle", 32'(bus.tx_ready), 32'd1);
        chk("tx_idle_high", 32'(bus.tx), 32'd1);
    endtask

    task automatic send_seq(input byte_q_t bytes);
        bit ok;
        bus.tx_byte = bytes[0];
        push_ok(bytes[0]);
        bus.tx_en = 1'b1;
        for (int i = 0; i < bytes.size(); i++) begin
            wait_ready_rise(ok);
            if (!ok) begin
                bus.tx_en = 1'b0;
                return;
            end
            if (i + 1 < bytes.size()) begin
                bus.tx_byte = bytes[i+1];
                push_ok(bytes[i+1]);
            end else begin
                bus.tx_en = 1'b0;
            end
        end
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop, input int unsigned stop_len);
        for (int unsigned k = 0; k < 10; k++) begin
            rx_drv = (k == 9) ? stop : frame_bit(b, k);
            repeat ((k == 9) ? stop_len : CPB) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        bit ok;
        int unsigned ev0;
        int unsigned hi_errs;
        logic [7:0] rb;
        byte_q_t seq;

        bus.tx_byte = 8'h00;
        bus.tx_en   = 1'b0;

        // Reset state
        repeat (5) @(negedge clk);
        chk("rst_tx", 32'(bus.tx), 32'd1);
        chk("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
        chk("rst_byte_read", 32'(bus.byte_read), 32'd0);
        chk("rst_rx_frame_err", 32'(bus.rx_frame_err), 32'd0);
        chk("rst_rx_byte", 32'(bus.rx_byte), 32'd0);
        rst_n = 1'b1;
        hi_errs = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.tx_ready !== 1'b0) hi_errs++;
        end
        chk("idle_line_200", 32'(hi_errs), 32'd0);

        // TX waveform for 8'hAB, tx_en dropped mid-frame
        bus.tx_byte = 8'hAB;
        push_ok(8'hAB);
        bus.tx_en = 1'b1;
        check_tx_frame(8'hAB);
        drain(12 * CPB);

        // Back-to-back loopback sequence
        seq = '{8'hAB, 8'hFF, 8'h00, 8'h12};
        send_seq(seq);
        drain(12 * CPB);

        // Random back-to-back loopback
        seq = {};
        for (int i = 0; i < 8; i++) seq.push_back(8'($urandom));
        send_seq(seq);
        drain(12 * CPB);

        // RX glitch shorter than half a bit
        loop_en = 1'b0;
        ev0 = n_events;
        rx_drv = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("glitch_no_event", 32'(n_events - ev0), 32'd0);

        // Directly driven good frames after the glitch
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom);
            push_ok(rb);
            drive_frame(rb, 1'b1, CPB);
        end
        drain(12 * CPB);

        // Framing error: stop bit low
        push_err();
        drive_frame(8'h5A, 1'b0, (3 * CPB) / 4);
        drain(12 * CPB);
        repeat (2 * CPB) @(negedge clk);
        chk("rx_byte_after_frame_err", 32'(bus.rx_byte), 32'(last_good));

        // Reset during TX data bit 4
        loop_en = 1'b1;
        bus.tx_byte = 8'($urandom);
        bus.tx_en = 1'b1;
        wait_tx_fall(ok);
        if (ok) begin
            repeat (5 * CPB + CPB / 2) @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            chk("rst_midframe_tx", 32'(bus.tx), 32'd1);
            chk("rst_midframe_tx_ready", 32'(bus.tx_ready), 32'd0);
            bus.tx_en = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            last_good = 8'h00;
            chk("rst_midframe_rx_byte", 32'(bus.rx_byte), 32'd0);
            repeat (20) @(negedge clk);
        end
        seq = '{8'h3C};
        send_seq(seq);
        drain(12 * CPB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/uart_txrx.md
Name: uart_txrx

Overview:
- 8N1 UART transceiver: one transmitter, one receiver, sharing one clock and one baud divisor.
- Default 9600 baud from a 100 MHz system clock.
- Sits between the core's byte-wide logic and the external serial pins.
- TX and RX are independent; loopback (tx wired to rx) is the primary verification configuration.

Parameters:
- CLKS_PER_BIT, 10417, clock cycles per serial bit (100 MHz / 9600, rounded); legal range ≥ 16.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- tx_byte  input  8  byte to transmit; sampled at end of start bit.
- tx_en  input  1  transmit enable; frames are sent back-to-back while high.
- tx_ready  output  1  frame-complete flag.
- tx  output  1  serial output, idle high.
- rx  input  1  serial input, asynchronous, idle high.
- rx_byte  output  8  last correctly received byte.
- byte_read  output  1  one-cycle pulse: rx_byte was updated.
- rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset (rst_n=0 on a clk edge):
  - tx=1, tx_ready=0, byte_read=0, rx_frame_err=0, rx_byte=8'h00.
  - Both FSMs go to IDLE; all counters are cleared.
  - Reset mid-frame aborts the frame immediately; tx returns high on the next edge.
- Frame format: start bit (0), data bits LSB first, stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: tx=1. If tx_en=1 → START and clear tx_ready. If tx_en=0, stay in IDLE; tx_ready holds its value.
  - START: tx=0 for CLKS_PER_BIT cycles. On the last cycle, latch tx_byte into the shift register, then → DATA.
  - DATA: drive shift[0]; shift right every CLKS_PER_BIT cycles; use an index 0..7; after bit 7 → STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then set tx_ready=1 and → IDLE.
  - With tx_en held high, tx_ready is high for exactly 1 cycle between frames. The next start bit begins the cycle after.
  - The inter-frame gap is at most 1 idle cycle.
  - tx_byte may change freely except on the latch cycle.
  - tx_en deasserting mid-frame does not abort the frame.
- RX:
  - Pass rx through a 2-FF synchronizer.
  - FSM states IDLE, START, DATA, STOP.
  - IDLE: a synchronized low → START; reset the bit counter.
  - START: at CLKS_PER_BIT/2 re-sample. If low → DATA with counter reset. If high (glitch) → IDLE.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit); shift into bit 7 and shift right (LSB first); after 8 samples → STOP.
  - STOP: sample at mid-bit.
    - High: rx_byte ← shift register and byte_read=1 for exactly one cycle.
    - Low: rx_frame_err=1 for one cycle; rx_byte unchanged.
    - In both cases → IDLE.
  - Returning to IDLE at mid-stop allows detection of a back-to-back start bit with zero gap.
  - rx_byte holds until the next valid frame.
- Latency (loopback): TX start-bit edge → byte_read pulse = 9.5 × CLKS_PER_BIT + 3 cycles, ±1.
- Counters must be wide enough for CLKS_PER_BIT−1; no wrap-around within a bit.
- No FIFO. An unread rx_byte is overwritten by the next valid frame.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles → tx=1, tx_ready=0, byte_read=0, rx_byte=8'h00. Line stays high 200 cycles after release with tx_en=0.
- Loopback sequence: tx→rx, tx_en=1. Present 8'hAB, 8'hFF, 8'h00, 8'h12, advancing on each tx_ready rising edge.
  - Four byte_read pulses yield AB, FF, 00, 12 in order.
  - All four complete within 4,270,560 ns at 100 MHz.
- TX waveform, byte 8'hAB:
  - tx low for 10417 cycles, then bits 1,1,0,1,0,1,0,1, each 10417 cycles, then high.
  - tx_ready pulses 1 cycle after the stop bit ends (104,170 cycles after the start edge).
- RX glitch: drive rx low for 3000 cycles, then high → no byte_read, no rx_frame_err, FSM back in IDLE.
- RX framing error: send 8'h5A with stop bit 0 → rx_frame_err one-cycle pulse, byte_read stays 0, rx_byte keeps its prior value.
- Reset mid-frame: assert rst_n=0 during TX bit 4 → tx=1 the next cycle. A subsequent frame of 8'h3C after release is received correctly.
